// File: rtl/fwnoc_ep_rx.sv
// fwnoc mesh endpoint receiver: parses header flits and forwards payload flits as a registered stream.
// Optional destination check enabled by defining FWNOC_EP_RX_CHECK_EN (counts and drops misrouted packets).
module fwnoc_ep_rx #(
    parameter int X_ID = 0,
    parameter int Y_ID = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] e_dat,
    input  logic        e_valid,
    output logic        e_ready,
    output logic [31:0] o_dat,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        o_last,
    output logic        hdr_valid,
    output logic [7:0]  hdr_src,
    output logic [7:0]  hdr_len,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_rem;
    logic       r_rdy_en;
    logic       w_o_free;
    logic       w_e_xfer;
    logic       w_mis;

    assign w_o_free = !o_valid || o_ready;
    // e_ready must read 0 while in reset, hence the enable flop rather than a constant
    assign e_ready  = r_rdy_en && ((r_state != S_PAY) || w_o_free);
    assign w_e_xfer = e_valid && e_ready;

`ifdef FWNOC_EP_RX_CHECK_EN
    localparam logic [7:0] L_X = X_ID[7:0];
    localparam logic [7:0] L_Y = Y_ID[7:0];

    assign w_mis = (e_dat[7:0] != L_X) || (e_dat[15:8] != L_Y);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= 16'h0000;
        end else if (r_state == S_HDR && w_e_xfer && w_mis && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'h0001;
        end
    end
`else
    assign w_mis   = 1'b0;
    assign err_cnt = 16'h0000;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_HDR;
            r_rem     <= 8'h00;
            r_rdy_en  <= 1'b0;
            o_dat     <= 32'h0000_0000;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            hdr_valid <= 1'b0;
            hdr_src   <= 8'h00;
            hdr_len   <= 8'h00;
        end else begin
            r_rdy_en  <= 1'b1;
            hdr_valid <= 1'b0;
            if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end
            case (r_state)
                S_HDR: begin
                    if (w_e_xfer) begin
                        hdr_src   <= e_dat[31:24];
                        hdr_len   <= e_dat[23:16];
                        r_rem     <= e_dat[23:16];
                        hdr_valid <= 1'b1;
                        if (e_dat[23:16] == 8'h00) begin
                            r_state <= S_HDR;
                        end else if (w_mis) begin
                            r_state <= S_DROP;
                        end else begin
                            r_state <= S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (w_e_xfer) begin
                        o_dat   <= e_dat;
                        o_valid <= 1'b1;
                        o_last  <= (r_rem == 8'h01);
                        r_rem   <= r_rem - 8'h01;
                        if (r_rem == 8'h01) begin
                            r_state <= S_HDR;
                        end
                    end
                end
                S_DROP: begin
                    if (w_e_xfer) begin
                        r_rem <= r_rem - 8'h01;
                        if (r_rem == 8'h01) begin
                            r_state <= S_HDR;
                        end
                    end
                end
                default: begin
                    r_state <= S_HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwnoc_ep_rx.sv
// Self-checking bench for fwnoc_ep_rx: packet-level reference model with queues, random handshakes.
module tb_fwnoc_ep_rx;

    localparam int X_ID = 3;
    localparam int Y_ID = 2;

    logic        clock;
    logic        reset_n;
    logic [31:0] e_dat;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] o_dat;
    logic        o_valid;
    logic        o_ready;
    logic        o_last;
    logic        hdr_valid;
    logic [7:0]  hdr_src;
    logic [7:0]  hdr_len;
    logic [15:0] err_cnt;

    fwnoc_ep_rx #(.X_ID(X_ID), .Y_ID(Y_ID)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .e_dat    (e_dat),
        .e_valid  (e_valid),
        .e_ready  (e_ready),
        .o_dat    (o_dat),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_last   (o_last),
        .hdr_valid(hdr_valid),
        .hdr_src  (hdr_src),
        .hdr_len  (hdr_len),
        .err_cnt  (err_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

`ifdef FWNOC_EP_RX_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // input flit stream, with a flag marking flits that must reach o_
    logic [31:0] in_q[$];
    bit          in_pay_q[$];
    logic [32:0] exp_o[$];     // {last, data}
    logic [16:0] exp_h[$];     // {misrouted, src, len}
    logic [15:0] exp_err;
    int          n_cmp;
    int          n_err;
    bit          prev_stall;
    logic [32:0] prev_o;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input logic [7:0] src, input int len, input logic [7:0] dx, input logic [7:0] dy);
        logic [7:0]  l8;
        logic [31:0] d;
        bit          mis;
        l8  = len[7:0];
        mis = CHK && ((dx != X_ID[7:0]) || (dy != Y_ID[7:0]));
        in_q.push_back({src, l8, dy, dx});
        in_pay_q.push_back(1'b0);
        exp_h.push_back({mis, src, l8});
        for (int i = 0; i < len; i++) begin
            d = $urandom;
            in_q.push_back(d);
            in_pay_q.push_back(!mis);
            if (!mis) exp_o.push_back({(i == len - 1), d});
        end
    endtask

    // called #1 after a rising edge; ends #1 after the next rising edge
    task automatic step(input int pv, input int pr);
        logic        exp_rdy;
        logic [16:0] h;
        e_valid = (in_q.size() > 0) && ($urandom_range(99) < pv);
        e_dat   = e_valid ? in_q[0] : $urandom;
        o_ready = ($urandom_range(99) < pr);
        #1;
        exp_rdy = !((in_q.size() > 0) && in_pay_q[0] && o_valid && !o_ready);
        chk("e_ready", e_ready, exp_rdy);
        if (prev_stall) chk("o_stable", {o_last, o_dat}, prev_o);
        if (o_valid && o_ready) begin
            chk("o_flit", {o_last, o_dat}, (exp_o.size() > 0) ? {31'b0, exp_o[0]} : {64{1'bx}});
            if (exp_o.size() > 0) void'(exp_o.pop_front());
        end
        if (e_valid && e_ready) begin
            void'(in_q.pop_front());
            void'(in_pay_q.pop_front());
        end
        prev_stall = o_valid && !o_ready;
        prev_o     = {o_last, o_dat};
        @(posedge clock);
        #1;
        if (hdr_valid) begin
            h = (exp_h.size() > 0) ? exp_h.pop_front() : 17'bx;
            chk("hdr_fields", {hdr_src, hdr_len}, h[15:0]);
            if (h[16] === 1'b1) exp_err++;
            chk("err_cnt", err_cnt, exp_err);
        end
    endtask

    task automatic drain(input int pv, input int pr);
        int c;
        c = 0;
        while ((in_q.size() > 0 || exp_o.size() > 0 || exp_h.size() > 0 || o_valid) && c < 5000) begin
            step(pv, pr);
            c++;
        end
        chk("drain_in_budget", (c < 5000), 1);
    endtask

    task automatic flush_model();
        in_q.delete();
        in_pay_q.delete();
        exp_o.delete();
        exp_h.delete();
        exp_err    = 16'h0;
        prev_stall = 1'b0;
    endtask

    initial begin
        int cyc;
        n_cmp   = 0;
        n_err   = 0;
        exp_err = 16'h0;
        prev_stall = 1'b0;
        prev_o  = '0;
        reset_n = 1'b0;
        e_valid = 1'b0;
        e_dat   = 32'h0;
        o_ready = 1'b0;
        #12;
        chk("rst_ctl", {e_ready, o_valid, o_last, hdr_valid, hdr_src, hdr_len}, 20'h0);
        chk("rst_dat", {o_dat, err_cnt}, 48'h0);
        #11 reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_rst", e_ready, 1'b1);

        // basic packet, sink always ready
        add_pkt(8'h05, 3, X_ID[7:0], Y_ID[7:0]);
        drain(100, 100);

        // same shape with a stalling sink
        for (int k = 0; k < 4; k++) add_pkt(8'h05, 3, X_ID[7:0], Y_ID[7:0]);
        drain(100, 50);

        // zero-length header immediately followed by a one-flit packet
        add_pkt(8'h11, 0, X_ID[7:0], Y_ID[7:0]);
        add_pkt(8'h12, 1, X_ID[7:0], Y_ID[7:0]);
        drain(100, 100);

        // misrouted packet, then a good one
        add_pkt(8'h21, 2, X_ID[7:0] + 8'd1, Y_ID[7:0]);
        add_pkt(8'h22, 1, X_ID[7:0], Y_ID[7:0]);
        drain(100, 100);
        chk("err_after_drop", err_cnt, CHK ? 16'd1 : 16'd0);

        // reset after one payload flit of a four-flit packet
        add_pkt(8'h31, 4, X_ID[7:0], Y_ID[7:0]);
        step(100, 100);
        step(100, 100);
        reset_n = 1'b0;
        #1;
        chk("midrst_ctl", {e_ready, o_valid, o_last, hdr_valid, hdr_src, hdr_len}, 20'h0);
        chk("midrst_dat", {o_dat, err_cnt}, 48'h0);
        flush_model();
        e_valid = 1'b0;
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;
        add_pkt(8'h32, 2, X_ID[7:0], Y_ID[7:0]);
        drain(100, 100);
        chk("hdr_len_held", hdr_len, 8'd2);

        // steady-state throughput: 50 packets of 4 payload flits
        for (int k = 0; k < 50; k++) add_pkt(k[7:0], 4, X_ID[7:0], Y_ID[7:0]);
        cyc = 0;
        while (in_q.size() > 0 && cyc < 1000) begin
            step(100, 100);
            cyc++;
        end
        chk("throughput_cycles", cyc, 250);
        drain(100, 100);

        // random mix of lengths, destinations and handshakes
        for (int k = 0; k < 40; k++) begin
            add_pkt($urandom, $urandom_range(6),
                    ($urandom_range(3) == 0) ? X_ID[7:0] + 8'd1 : X_ID[7:0],
                    ($urandom_range(3) == 0) ? Y_ID[7:0] + 8'd2 : Y_ID[7:0]);
        end
        drain(70, 60);
        chk("final_err_cnt", err_cnt, exp_err);
        chk("hdr_queue_empty", exp_h.size(), 0);
        chk("out_queue_empty", exp_o.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
